// File: rtl/iir_stream_adapter.sv
// iir_stream_adapter
//
// Puts a valid/ready stream in front of the `iir` filter core and another one
// behind it. The core takes one `x` and produces one `y` every clock and has
// no flow control. The adapter does four things:
//   - Registers accepted samples onto `x`.
//   - Tags every accept and delays the tag by the filter latency.
//   - Captures only the tagged `y` values into an output FIFO.
//   - Holds one credit per FIFO entry, so a result always has a slot when it
//     arrives, even under downstream backpressure.
//
// Parameters
//   DW          sample width (matches the filter x/y width)
//   FILT_LAT    clock edges from a change on x to the matching change on y (0..8)
//   OFIFO_DEPTH output FIFO entries and total credits (power of 2, >= 2)
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   s_valid  input sample valid
//   s_ready  adapter can accept a sample (credits available)
//   s_data   input sample
//   x        sample driven to the filter
//   y        filter output
//   m_valid  output result valid (FIFO not empty)
//   m_ready  downstream accepts the result
//   m_data   filtered result (FIFO head)
//
// Build option
//   IIR_ADAPT_HOLD_EN  when defined, x holds the last accepted sample on
//                      non-accept cycles instead of being forced to 0.

module iir_stream_adapter #(
    parameter int DW          = 32,
    parameter int FILT_LAT    = 1,
    parameter int OFIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic [DW-1:0] x,
    input  logic [DW-1:0] y,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data
);

    localparam int AW = $clog2(OFIFO_DEPTH);
    localparam int CW = $clog2(OFIFO_DEPTH + 1);

    logic [CW-1:0]   credits;
    logic [CW-1:0]   count;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [FILT_LAT:0] tag;
    logic [DW-1:0]   mem [OFIFO_DEPTH];

    logic accept;
    logic pop;
    logic capture;

    assign s_ready = (credits != '0);
    assign m_valid = (count != '0);
    assign m_data  = mem[rd_ptr];

    assign accept  = s_valid && s_ready;
    assign pop     = m_valid && m_ready;
    // The tag at the end of the pipeline lines up with the y produced from
    // the x driven when that tag entered.
    assign capture = tag[FILT_LAT];

    // Sample drive and tag pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x   <= '0;
            tag <= '0;
        end else begin
            if (accept) begin
                x <= s_data;
            end else begin
`ifdef IIR_ADAPT_HOLD_EN
                x <= x;
`else
                x <= '0;
`endif
            end
            tag[0] <= accept;
            for (int i = 1; i <= FILT_LAT; i++) begin
                tag[i] <= tag[i-1];
            end
        end
    end

    // Credits: each accept reserves a FIFO slot, and each pop frees one.
    // Because of this, a capture can never find the FIFO full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits <= CW'(OFIFO_DEPTH);
        end else begin
            case ({accept, pop})
                2'b10:   credits <= credits - CW'(1);
                2'b01:   credits <= credits + CW'(1);
                default: credits <= credits;
            endcase
        end
    end

    // Output FIFO. The depth is a power of 2, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < OFIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (capture) begin
                mem[wr_ptr] <= y;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({capture, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
